// File: rtl/dual_ahb_ram_pkg.sv
// Shared AHB encodings, port state enum and byte-lane helper for dual_ahb_ram.
package p_ahb;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    PORT_IDLE = 2'd0,
    PORT_DATA = 2'd1,
    PORT_ERR1 = 2'd2,
    PORT_ERR2 = 2'd3
  } port_state_t;

  // Lane pattern is shifted by the raw address; oversized transfers count as words.
  function automatic logic [3:0] f_ahb_be(input logic [1:0] addr, input logic [2:0] size);
    logic [3:0] base;
    case (size)
      HSIZE_BYTE: base = 4'b0001;
      HSIZE_HALF: base = 4'b0011;
      default:    base = 4'b1111;
    endcase
    return base << addr;
  endfunction

endpackage

// File: rtl/dahb_port.sv
// One AHB3-Lite slave port: data-phase registers, byte enables and response FSM.
// With DAHB_RAM_ERROR_RESP_EN defined, oversized/misaligned transfers get a two-cycle ERROR.
//
// state     | meaning
// PORT_IDLE | no data phase in progress
// PORT_DATA | OKAY data phase of an accepted transfer
// PORT_ERR1 | first ERROR cycle, hready low
// PORT_ERR2 | second ERROR cycle, hready high, may accept next transfer
module dahb_port
  import p_ahb::*;
#(
  parameter int MEM_MSB = 19
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [MEM_MSB:0]   haddr,
  input  logic [2:0]         hsize,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic               hsel,
  output logic               hready,
  output logic               hresp,
  output logic               rd_en,
  output logic               wr_en,
  output logic [MEM_MSB-2:0] idx,
  output logic [3:0]         be
);

`ifdef DAHB_RAM_ERROR_RESP_EN
  localparam logic ERR_RESP = 1'b1;
`else
  localparam logic ERR_RESP = 1'b0;
`endif

  port_state_t state, state_nxt;
  logic        accept;
  logic        err;
  logic        r_write;

  assign accept = hsel & (htrans inside {HTRANS_NONSEQ, HTRANS_SEQ}) & hready;

`ifdef DAHB_RAM_ERROR_RESP_EN
  assign err = (hsize > HSIZE_WORD)
             | ((hsize == HSIZE_HALF) & haddr[0])
             | ((hsize == HSIZE_WORD) & (haddr[1:0] != 2'b00));
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= PORT_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = PORT_IDLE;
    case (state)
      PORT_ERR1: state_nxt = PORT_ERR2;
      default:   if (accept) state_nxt = err ? PORT_ERR1 : PORT_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx     <= haddr[MEM_MSB:2];
      be      <= f_ahb_be(haddr[1:0], hsize);
      r_write <= hwrite;
    end
  end

  // Gating the write with resetn drops a write whose data phase meets reset.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    case (state)
      PORT_DATA: begin
        rd_en = ~r_write;
        wr_en = r_write & resetn;
      end
      PORT_ERR1: begin
        hready = 1'b0;
        hresp  = ERR_RESP;
      end
      PORT_ERR2: hresp = ERR_RESP;
      default: ;
    endcase
  end

endmodule

// File: rtl/dual_ahb_ram.sv
// Two-port AHB3-Lite RAM sharing one word array (backdoor: <inst>.ahb_dmem.r_memory).
// Optional error responses are enabled by defining DAHB_RAM_ERROR_RESP_EN.
module dual_ahb_ram
  import p_ahb::*;
#(
  parameter int unsigned MEM_SIZE   = 32'h100000,
  parameter int          SIMULATION = 1,
  parameter int          ENABLE_LOG = 0,
  parameter              LABEL      = "MEMORY",
  localparam int         MEM_MSB    = $clog2(MEM_SIZE) - 1
) (
  input  logic             s_clk_i,
  input  logic             s_resetn_i,
  input  logic [MEM_MSB:0] s_haddr_i     [2],
  input  logic [31:0]      s_hwdata_i    [2],
  input  logic [2:0]       s_hburst_i    [2],
  input  logic             s_hmastlock_i [2],
  input  logic [3:0]       s_hprot_i     [2],
  input  logic [2:0]       s_hsize_i     [2],
  input  logic [1:0]       s_htrans_i    [2],
  input  logic             s_hwrite_i    [2],
  input  logic             s_hsel_i      [2],
  output logic [31:0]      s_hrdata_o    [2],
  output logic             s_hready_o    [2],
  output logic             s_hresp_o     [2]
);

  localparam int unsigned WORDS     = MEM_SIZE / 4;
  localparam logic [31:0] INIT_WORD = (SIMULATION != 0) ? '0 : 'x;

  if ((MEM_SIZE < 8) || ((MEM_SIZE & (MEM_SIZE - 1)) != 0)) begin : g_bad_size
    $error("MEM_SIZE must be a power of two and at least 8");
  end
  if ((ENABLE_LOG < 0) || (ENABLE_LOG > 1)) begin : g_bad_log
    $error("ENABLE_LOG must be 0 or 1");
  end
  if (LABEL == '0) begin : g_bad_label
    $error("LABEL must not be empty");
  end

  logic [1:0]         rd_en;
  logic [1:0]         wr_en;
  logic [MEM_MSB-2:0] idx [2];
  logic [3:0]         be  [2];
  logic               unused_ok;

  assign unused_ok = ^{s_hburst_i[0], s_hburst_i[1], s_hmastlock_i[0], s_hmastlock_i[1],
                       s_hprot_i[0], s_hprot_i[1]};

  for (genvar p = 0; p < 2; p++) begin : g_port
    dahb_port #(.MEM_MSB(MEM_MSB)) u_port (
      .clk    (s_clk_i),
      .resetn (s_resetn_i),
      .haddr  (s_haddr_i[p]),
      .hsize  (s_hsize_i[p]),
      .htrans (s_htrans_i[p]),
      .hwrite (s_hwrite_i[p]),
      .hsel   (s_hsel_i[p]),
      .hready (s_hready_o[p]),
      .hresp  (s_hresp_o[p]),
      .rd_en  (rd_en[p]),
      .wr_en  (wr_en[p]),
      .idx    (idx[p]),
      .be     (be[p])
    );
  end

  if (1) begin : ahb_dmem
    logic [31:0] r_memory [WORDS] = '{default: INIT_WORD};

    // Port 0 is applied last so it owns any lane both ports hit on the same word.
    always_ff @(posedge s_clk_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_en[1] && be[1][b]) r_memory[idx[1]][8*b +: 8] <= s_hwdata_i[1][8*b +: 8];
        if (wr_en[0] && be[0][b]) r_memory[idx[0]][8*b +: 8] <= s_hwdata_i[0][8*b +: 8];
      end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
      assign s_hrdata_o[p] = rd_en[p] ? r_memory[idx[p]] : '0;
    end
  end

endmodule

// File: tb/tb_dual_ahb_ram.sv
// Bench for dual_ahb_ram: vector table, hand-written dual-port sequences and a port-0 model run.
module tb_dual_ahb_ram;
  import p_ahb::*;

  localparam int MEM_SIZE = 1024;
  localparam int AW       = 10;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] haddr     [2];
  logic [31:0]   hwdata    [2];
  logic [2:0]    hburst    [2];
  logic          hmastlock [2];
  logic [3:0]    hprot     [2];
  logic [2:0]    hsize     [2];
  logic [1:0]    htrans    [2];
  logic          hwrite    [2];
  logic          hsel      [2];
  logic [31:0]   hrdata    [2];
  logic          hready    [2];
  logic          hresp     [2];

  always #5 clk = ~clk;

  dual_ahb_ram #(
    .MEM_SIZE(MEM_SIZE), .SIMULATION(1), .ENABLE_LOG(0), .LABEL("TBMEM")
  ) dut (
    .s_clk_i(clk), .s_resetn_i(resetn),
    .s_haddr_i(haddr), .s_hwdata_i(hwdata), .s_hburst_i(hburst),
    .s_hmastlock_i(hmastlock), .s_hprot_i(hprot), .s_hsize_i(hsize),
    .s_htrans_i(htrans), .s_hwrite_i(hwrite), .s_hsel_i(hsel),
    .s_hrdata_o(hrdata), .s_hready_o(hready), .s_hresp_o(hresp)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    int          port;
    bit          wr;
    logic [9:0]  addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  sb_t         sb_q0[$];
  sb_t         sb_q1[$];
  bit          issued [2];
  bit          in_dp  [2];
  bit          mon_en = 1'b0;
  logic [31:0] nxt_wdata [2];
  logic [31:0] ref_m [16];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int p, bit sel, logic [1:0] tr, bit wr, logic [AW-1:0] a,
                       logic [2:0] sz, logic [31:0] wd, logic [31:0] exp, string name);
    sb_t e;
    hsel[p] = sel; htrans[p] = tr; hwrite[p] = wr; haddr[p] = a; hsize[p] = sz;
    nxt_wdata[p] = wd;
    if (sel && tr[1]) begin
      e.name = name;
      e.exp  = wr ? 32'h0 : exp;
      if (p == 0) sb_q0.push_back(e); else sb_q1.push_back(e);
      issued[p] = 1'b1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      in_dp[p] = issued[p]; issued[p] = 1'b0;
      hwdata[p] = nxt_wdata[p]; nxt_wdata[p] = '0;
      hsel[p] = 1'b0; htrans[p] = HTRANS_IDLE; hwrite[p] = 1'b0;
      haddr[p] = '0; hsize[p] = HSIZE_WORD;
    end
  endtask

  task automatic mon_port(int p);
    sb_t e;
    if (in_dp[p]) begin
      if ((p == 0 && sb_q0.size() == 0) || (p == 1 && sb_q1.size() == 0)) begin
        checks++; errors++;
        $display("FAIL sb_underflow p%0d: got empty queue expected an entry", p);
        return;
      end
      if (p == 0) e = sb_q0.pop_front(); else e = sb_q1.pop_front();
      chk($sformatf("%s hready", e.name), 32'(hready[p]), 32'h1);
      chk($sformatf("%s hresp", e.name), 32'(hresp[p]), 32'h0);
      chk($sformatf("%s hrdata", e.name), hrdata[p], e.exp);
    end else begin
      chk($sformatf("idle_p%0d hrdata", p), hrdata[p], 32'h0);
      chk($sformatf("idle_p%0d hready", p), 32'(hready[p]), 32'h1);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_port(0);
      mon_port(1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] lane_mask(logic [1:0] a, logic [2:0] sz);
    case (sz)
      3'd0:    return 32'h0000_00FF << (8 * a);
      3'd1:    return a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  initial begin
    vec_t vecs [12];
    vecs[0]  = '{1, 1'b0, 10'h000, 3'd2, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[1]  = '{0, 1'b1, 10'h005, 3'd0, 32'hAAAA_AAAA, 32'h0};
    vecs[2]  = '{0, 1'b0, 10'h004, 3'd2, 32'h0000_0000, 32'h0000_AA00};
    vecs[3]  = '{0, 1'b1, 10'h006, 3'd1, 32'hBEEF_BEEF, 32'h0};
    vecs[4]  = '{1, 1'b0, 10'h004, 3'd2, 32'h0000_0000, 32'hBEEF_AA00};
    vecs[5]  = '{1, 1'b1, 10'h008, 3'd2, 32'h1234_5678, 32'h0};
    vecs[6]  = '{1, 1'b0, 10'h008, 3'd2, 32'h0000_0000, 32'h1234_5678};
    vecs[7]  = '{1, 1'b1, 10'h00B, 3'd0, 32'h9999_9999, 32'h0};
    vecs[8]  = '{0, 1'b0, 10'h008, 3'd2, 32'h0000_0000, 32'h9934_5678};
    vecs[9]  = '{0, 1'b1, 10'h00C, 3'd1, 32'h5A5A_5A5A, 32'h0};
    vecs[10] = '{0, 1'b0, 10'h00C, 3'd0, 32'h0000_0000, 32'h0000_5A5A};
    vecs[11] = '{1, 1'b0, 10'h001, 3'd0, 32'h0000_0000, 32'hDEAD_BEEF};

    for (int p = 0; p < 2; p++) begin
      hburst[p] = 3'd1; hmastlock[p] = 1'b0; hprot[p] = 4'h3;
      hwdata[p] = '0; nxt_wdata[p] = '0; issued[p] = 1'b0; in_dp[p] = 1'b0;
      hsel[p] = 1'b0; htrans[p] = HTRANS_IDLE; hwrite[p] = 1'b0;
      haddr[p] = '0; hsize[p] = HSIZE_WORD;
    end
    for (int i = 0; i < 16; i++) ref_m[i] = 32'h0;

    resetn = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("reset_p%0d hready", p), 32'(hready[p]), 32'h1);
      chk($sformatf("reset_p%0d hresp", p), 32'(hresp[p]), 32'h0);
      chk($sformatf("reset_p%0d hrdata", p), hrdata[p], 32'h0);
    end
    dut.ahb_dmem.r_memory[0] = 32'hDEAD_BEEF;
    dut.ahb_dmem.r_memory[8] = 32'h0BAD_F00D;
    next_cycle();
    resetn = 1'b1;
    mon_en = 1'b1;
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].port, 1'b1, HTRANS_NONSEQ, vecs[i].wr, vecs[i].addr, vecs[i].size,
            vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
      next_cycle();
    end
    next_cycle();

    drive(0, 1'b1, HTRANS_NONSEQ, 1'b1, 10'h010, HSIZE_WORD, 32'h1111_1111, 32'h0, "both_wr0");
    drive(1, 1'b1, HTRANS_NONSEQ, 1'b1, 10'h010, HSIZE_WORD, 32'h2222_2222, 32'h0, "both_wr1");
    next_cycle();
    drive(0, 1'b1, HTRANS_SEQ, 1'b1, 10'h014, HSIZE_HALF, 32'h3333_3333, 32'h0, "part_wr0");
    drive(1, 1'b1, HTRANS_SEQ, 1'b1, 10'h014, HSIZE_WORD, 32'h4444_4444, 32'h0, "part_wr1");
    next_cycle();
    drive(0, 1'b1, HTRANS_NONSEQ, 1'b0, 10'h010, HSIZE_WORD, 32'h0, 32'h1111_1111, "both_rd");
    drive(1, 1'b1, HTRANS_NONSEQ, 1'b0, 10'h014, HSIZE_WORD, 32'h0, 32'h4444_3333, "part_rd");
    next_cycle();
    next_cycle();
    chk("both_wr mem[4]", dut.ahb_dmem.r_memory[4], 32'h1111_1111);
    chk("part_wr mem[5]", dut.ahb_dmem.r_memory[5], 32'h4444_3333);

    drive(0, 1'b1, HTRANS_NONSEQ, 1'b1, 10'h020, HSIZE_WORD, 32'h5555_5555, 32'h0, "rw_wr");
    drive(1, 1'b1, HTRANS_NONSEQ, 1'b0, 10'h020, HSIZE_WORD, 32'h0, 32'h0BAD_F00D, "rw_old");
    next_cycle();
    drive(1, 1'b1, HTRANS_NONSEQ, 1'b0, 10'h020, HSIZE_WORD, 32'h0, 32'h5555_5555, "rw_new");
    next_cycle();
    next_cycle();

    drive(0, 1'b0, HTRANS_NONSEQ, 1'b1, 10'h030, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0, "nosel");
    drive(1, 1'b1, HTRANS_IDLE, 1'b1, 10'h030, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0, "idle");
    next_cycle();
    drive(0, 1'b1, HTRANS_BUSY, 1'b1, 10'h030, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0, "busy");
    next_cycle();
    next_cycle();
    chk("nosel_idle mem[12]", dut.ahb_dmem.r_memory[12], 32'h0);
    drive(1, 1'b1, HTRANS_NONSEQ, 1'b0, 10'h030, HSIZE_WORD, 32'h0, 32'h0, "nosel_rd");
    next_cycle();
    next_cycle();

    drive(0, 1'b1, HTRANS_NONSEQ, 1'b1, 10'h040, HSIZE_WORD, 32'h7777_7777, 32'h0, "rst_wr");
    next_cycle();
    resetn = 1'b0;
    next_cycle();
    next_cycle();
    resetn = 1'b1;
    chk("rst_wr mem[16]", dut.ahb_dmem.r_memory[16], 32'h0);
    drive(0, 1'b1, HTRANS_NONSEQ, 1'b0, 10'h040, HSIZE_WORD, 32'h0, 32'h0, "rst_rd");
    next_cycle();
    next_cycle();

`ifdef DAHB_RAM_ERROR_RESP_EN
    mon_en = 1'b0;
    hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; hwrite[0] = 1'b1;
    haddr[0] = 10'h002; hsize[0] = HSIZE_WORD; nxt_wdata[0] = 32'hFFFF_FFFF;
    next_cycle();
    @(negedge clk);
    chk("err1 hready", 32'(hready[0]), 32'h0);
    chk("err1 hresp", 32'(hresp[0]), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("err2 hready", 32'(hready[0]), 32'h1);
    chk("err2 hresp", 32'(hresp[0]), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("err_done hresp", 32'(hresp[0]), 32'h0);
    chk("err mem[0]", dut.ahb_dmem.r_memory[0], 32'hDEAD_BEEF);
    next_cycle();
    mon_en = 1'b1;
`endif

    for (int i = 0; i < 48; i++) begin
      logic [3:0]  w;
      logic [1:0]  off;
      logic [2:0]  sz;
      logic [31:0] wd;
      logic [31:0] m;
      bit          wr;
      w   = 4'($urandom_range(0, 15));
      sz  = 3'($urandom_range(0, 2));
      off = (sz == 3'd0) ? 2'($urandom_range(0, 3)) : (sz == 3'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      drive(0, 1'b1, HTRANS_NONSEQ, wr, {4'h4, w, off}, sz, wd, ref_m[w], $sformatf("rnd%0d", i));
      if (wr) begin
        m = lane_mask(off, sz);
        ref_m[w] = (ref_m[w] & ~m) | (wd & m);
      end
      next_cycle();
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb_q0.size() + sb_q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
